// File: rtl/i2s_pkg.sv
// i2s_pkg: shared scheduler state encoding, default word width and channel codes.
package i2s_pkg;
    localparam int DW_DEF = 16;
    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/i2s_pair_fifo.sv
// i2s_pair_fifo: synchronous stereo-pair FIFO with occupancy output; caller gates push/pop.
module i2s_pair_fifo
    import i2s_pkg::*;
#(
    parameter int W = 2 * DW_DEF,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    assign rdata = mem[rptr];
    assign full = level == (AW + 1)'(DEPTH);
    always_ff @(posedge clk_in)
        if (push) mem[wptr] <= wdata;
    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge rstn)
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
endmodule

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched: buffers stereo pairs and hands the I2S master one word per send_over rising edge.
module i2s_tx_sched
    import i2s_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int DEPTH = 4,
    parameter int MUTE_UR = 1
) (
    input  logic                     clk_in,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     wr_valid,
    input  logic [DW-1:0]            wr_left,
    input  logic [DW-1:0]            wr_right,
    output logic                     wr_ready,
    input  logic                     send_over,
    output logic                     i2s_enable,
    output logic [DW-1:0]            i2s_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               underrun_cnt
);
    state_t state, state_n;
    logic ch, ch_n, en_n, so_q, wd, pop, full;
    logic [DW-1:0] hold_l, hold_r, hl_n, hr_n, data_n, pl, pr;
    logic [7:0] cnt_n;
    logic [2*DW-1:0] rdata;
    assign wd = send_over & ~so_q;
    assign wr_ready = ~full;
    assign busy = state != IDLE;
    assign {pl, pr} = rdata;
    i2s_pair_fifo #(.W(2 * DW), .DEPTH(DEPTH)) u_fifo (
        .clk_in(clk_in),
        .rstn(rstn),
        .push(wr_valid & ~full),
        .pop(pop),
        .wdata({wr_left, wr_right}),
        .rdata(rdata),
        .full(full),
        .level(fifo_level)
    );
    always_ff @(posedge clk_in or negedge rstn)
        if (!rstn) begin
            state        <= IDLE;
            ch           <= CH_L;
            so_q         <= 1'b0;
            i2s_enable   <= 1'b0;
            i2s_data     <= '0;
            hold_l       <= '0;
            hold_r       <= '0;
            underrun_cnt <= '0;
        end else begin
            state        <= state_n;
            ch           <= ch_n;
            so_q         <= send_over;
            i2s_enable   <= en_n;
            i2s_data     <= data_n;
            hold_l       <= hl_n;
            hold_r       <= hr_n;
            underrun_cnt <= cnt_n;
        end
    // Pop decisions use the registered level, so a same-cycle push never feeds an empty pop.
    always_comb begin
        state_n = state;
        ch_n    = ch;
        en_n    = i2s_enable;
        data_n  = i2s_data;
        hl_n    = hold_l;
        hr_n    = hold_r;
        cnt_n   = underrun_cnt;
        pop     = 1'b0;
        if (state == IDLE) begin
            if (start && fifo_level != '0) begin
                pop     = 1'b1;
                hl_n    = pl;
                hr_n    = pr;
                data_n  = pl;
                en_n    = 1'b1;
                ch_n    = CH_L;
                state_n = RUN;
            end
        end else begin
            if (wd) begin
                ch_n = ~ch;
                if (ch == CH_L) data_n = hold_r;
                else if (state == DRAIN) begin
                    en_n    = 1'b0;
                    data_n  = '0;
                    state_n = IDLE;
                end else if (fifo_level != '0) begin
                    pop    = 1'b1;
                    hl_n   = pl;
                    hr_n   = pr;
                    data_n = pl;
                end else begin
                    if (MUTE_UR != 0) begin
                        hl_n = '0;
                        hr_n = '0;
                    end
                    data_n = (MUTE_UR != 0) ? '0 : hold_l;
                    cnt_n  = (underrun_cnt == 8'hFF) ? underrun_cnt : underrun_cnt + 8'd1;
                end
            end
            if (state == RUN && stop) state_n = DRAIN;
        end
    end
endmodule
